fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage: owns the architectural PC, issues single-outstanding
//   requests to instruction memory and presents {pc, instr} to decode through a
//   one-entry output register. Consumes the branch unit's redirect (br_taken/new_pc)
//   from EX, flushing the fetched instruction and discarding in-flight responses.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   NOP_INSTR 32'h0000_0013  if_instr value when nothing valid (addi x0,x0,0)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   br_taken     in   1   EX redirect request, single-cycle pulse
//   new_pc       in   32  redirect target, sampled when br_taken=1
//   stall        in   1   decode cannot accept if_* this cycle
//   imem_req     out  1   fetch request, one cycle per fetch
//   imem_addr    out  32  fetch address, valid while imem_req=1
//   imem_rvalid  in   1   response valid, >=1 cycle after imem_req
//   imem_rdata   in   32  instruction word, valid with imem_rvalid
//   if_valid     out  1   if_pc/if_instr hold a valid instruction
//   if_pc        out  32  PC of presented instruction
//   if_instr     out  32  presented instruction
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, state=FETCH, if_valid=0, if_pc=RESET_PC,
//     if_instr=NOP_INSTR; imem_req forced 0 while rst=1.
//   States: FETCH (may issue), WAIT (request outstanding), DROP (stale request
//     outstanding, response to be discarded).
//   Consume: output register freed at an edge where if_valid=1 and stall=0.
//   imem_req = !rst & state==FETCH & !br_taken & (!if_valid | !stall)  (comb).
//   imem_addr = pc (comb); pc is the address of the next instruction to fetch.
//   FETCH: imem_req=1 -> WAIT next cycle; otherwise stay.
//   WAIT: imem_rvalid=1 -> if_instr<=imem_rdata, if_pc<=pc, if_valid<=1,
//     pc<=pc+4, -> FETCH. No rvalid -> stay. Request only issued when register is
//     free/being consumed, so capture never overwrites an unconsumed entry.
//   DROP: imem_rvalid=1 -> response discarded, -> FETCH.
//   Redirect (br_taken=1 at edge), highest priority in every state:
//     pc<={new_pc[31:2],2'b00}; if_valid<=0, if_instr<=NOP_INSTR;
//     FETCH -> FETCH (request suppressed that cycle); WAIT & !rvalid -> DROP;
//     WAIT & rvalid -> FETCH, response discarded, pc not incremented;
//     DROP & !rvalid -> DROP; DROP & rvalid -> FETCH.
//   if_valid clears on consume when no capture that edge; outputs hold while stall=1.
//   imem_rvalid in FETCH ignored (e.g. response outstanding across reset).
//   pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
//   Throughput: one instruction per 2 cycles with 1-cycle memory latency.
//   Latency: redirect at edge N -> imem_addr=new target in cycle N+1
//     (from FETCH, or DROP with rvalid at N).
// TESTING
//   1 Reset, 1-cycle imem returning addr^32'hA5A5_0000 -> imem_addr 0,4,8; if_pc
//     0,4,8 with matching if_instr; imem_req never high twice before a response.
//   2 stall=1 for 5 cycles with if_valid=1 -> if_pc/if_instr stable, imem_req=0;
//     release -> next request issued that cycle, fetch resumes at pc+4.
//   3 br_taken, new_pc=32'h0000_0102, in WAIT with response delayed 3 cycles ->
//     DROP, stale rdata never on if_instr, next imem_addr=32'h0000_0100.
//   4 br_taken coincident with imem_rvalid in WAIT -> response discarded,
//     if_valid=0, next imem_addr=new target; br_taken in FETCH -> imem_req=0 that
//     cycle, target fetched next cycle.
//   5 RESET_PC=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
//   6 Assert rst during WAIT -> all outputs at reset values immediately (async);
//     late imem_rvalid after release ignored, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps a single imem request in flight and
// presents {pc, instr} to decode through a one-entry output register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] new_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [1:0]  dbg_state
);

    // Handshakes: imem_req is a one-cycle request pulse; imem_rvalid returns its
    // single response one or more cycles later. Toward decode, if_valid is the
    // valid and !stall the ready; an entry is consumed at an edge with both high.

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_DROP  = 2'b10;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic        valid_nx;
    logic [31:0] if_pc_nx;
    logic [31:0] if_instr_nx;
    logic        consume;

    assign consume   = if_valid & ~stall;
    assign imem_addr = pc;
    assign dbg_state = state;

    // Only issue when the output register is empty or drains at this edge, so a
    // capture can never overwrite an entry decode has not taken yet.
    assign imem_req = ~rst & (state == ST_FETCH) & ~br_taken & (~if_valid | ~stall);

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        valid_nx    = if_valid;
        if_pc_nx    = if_pc;
        if_instr_nx = if_instr;

        if (br_taken) begin
            pc_nx       = {new_pc[31:2], 2'b00};
            valid_nx    = 1'b0;
            if_instr_nx = NOP_INSTR;
            case (state)
                ST_FETCH: state_nx = ST_FETCH;
                ST_WAIT:  state_nx = imem_rvalid ? ST_FETCH : ST_DROP;
                ST_DROP:  state_nx = imem_rvalid ? ST_FETCH : ST_DROP;
                default:  state_nx = ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (consume) valid_nx = 1'b0;
                    if (imem_req) state_nx = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        valid_nx    = 1'b1;
                        if_pc_nx    = pc;
                        if_instr_nx = imem_rdata;
                        pc_nx       = pc + 32'd4;
                        state_nx    = ST_FETCH;
                    end else if (consume) begin
                        valid_nx = 1'b0;
                    end
                end
                ST_DROP: begin
                    // The response belongs to a path abandoned by a redirect.
                    if (consume) valid_nx = 1'b0;
                    if (imem_rvalid) state_nx = ST_FETCH;
                end
                default: begin
                    state_nx = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            if_valid <= valid_nx;
            if_pc    <= if_pc_nx;
            if_instr <= if_instr_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for the main fetch,
// stall and redirect flows, plus hand sequences for async reset and PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  SF  = 2'b00;
    localparam logic [1:0]  SW  = 2'b01;
    localparam logic [1:0]  SD  = 2'b10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, br_taken, stall, imem_rvalid;
    logic [31:0] new_pc, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_instr;
    logic [1:0]  dbg_state;

    logic        r2_rst, r2_br, r2_stall, r2_rvalid;
    logic [31:0] r2_npc, r2_rdata;
    logic        r2_req, r2_valid;
    logic [31:0] r2_addr, r2_pc, r2_instr;
    logic [1:0]  r2_state;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .br_taken(br_taken), .new_pc(new_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .dbg_state(dbg_state)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(r2_rst), .br_taken(r2_br), .new_pc(r2_npc), .stall(r2_stall),
        .imem_req(r2_req), .imem_addr(r2_addr), .imem_rvalid(r2_rvalid),
        .imem_rdata(r2_rdata), .if_valid(r2_valid), .if_pc(r2_pc),
        .if_instr(r2_instr), .dbg_state(r2_state)
    );

    typedef struct {
        logic        br;
        logic [31:0] npc;
        logic        stl;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [1:0]  e_st;
        logic        chk_instr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic pending = 1'b0;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic br, input logic [31:0] npc, input logic stl,
                        input logic rv, input logic [31:0] rd, input logic e_req,
                        input logic [31:0] e_addr, input logic e_v, input logic [1:0] e_st,
                        input logic chk_instr, input logic [31:0] e_pc,
                        input logic [31:0] e_instr);
        vec_t v;
        v.br = br; v.npc = npc; v.stl = stl; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_st = e_st;
        v.chk_instr = chk_instr; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic br, input logic [31:0] npc, input logic stl,
                         input logic rv, input logic [31:0] rd);
        br_taken = br; new_pc = npc; stall = stl; imem_rvalid = rv; imem_rdata = rd;
    endtask

    // Compares all outputs of the main instance; if_pc/if_instr are only
    // meaningful when valid, or when a known NOP is expected after reset/redirect.
    task automatic expect_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_v, input logic [1:0] e_st, input logic chk_instr,
                               input logic [31:0] e_pc, input logic [31:0] e_instr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, "_addr"}, imem_addr, e_addr);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, e_v});
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, e_st});
        if (e_v) chk({tag, "_pc"}, if_pc, e_pc);
        if (e_v || chk_instr) chk({tag, "_instr"}, if_instr, e_instr);
        if (imem_req) chk({tag, "_one_outstanding"}, {31'd0, pending}, 32'd0);
        if (imem_rvalid) pending = 1'b0;
        if (imem_req) pending = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        r2_rst = 1'b1; r2_br = 1'b0; r2_npc = 32'd0; r2_stall = 1'b0;
        r2_rvalid = 1'b0; r2_rdata = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, SF});

        // br, npc, stall, rvalid, rdata | req, addr, valid, state, chk_instr, pc, instr
        addv(0, 0, 0, 0, 0,             1, 32'h0,   0, SF, 1, 0,       NOP);
        addv(0, 0, 0, 1, ins(32'h0),    0, 32'h0,   0, SW, 1, 0,       NOP);
        addv(0, 0, 0, 0, 0,             1, 32'h4,   1, SF, 1, 32'h0,   ins(32'h0));
        addv(0, 0, 0, 1, ins(32'h4),    0, 32'h4,   0, SW, 0, 0,       0);
        addv(0, 0, 0, 0, 0,             1, 32'h8,   1, SF, 1, 32'h4,   ins(32'h4));
        addv(0, 0, 0, 1, ins(32'h8),    0, 32'h8,   0, SW, 0, 0,       0);
        for (int k = 0; k < 5; k++)
            addv(0, 0, 1, 0, 0,         0, 32'hC,   1, SF, 1, 32'h8,   ins(32'h8));
        addv(0, 0, 0, 0, 0,             1, 32'hC,   1, SF, 1, 32'h8,   ins(32'h8));
        addv(0, 0, 0, 1, ins(32'hC),    0, 32'hC,   0, SW, 0, 0,       0);
        addv(0, 0, 0, 0, 0,             1, 32'h10,  1, SF, 1, 32'hC,   ins(32'hC));
        addv(1, 32'h102, 0, 0, 0,       0, 32'h10,  0, SW, 0, 0,       0);
        addv(0, 0, 0, 0, 0,             0, 32'h100, 0, SD, 1, 0,       NOP);
        addv(0, 0, 0, 0, 0,             0, 32'h100, 0, SD, 1, 0,       NOP);
        addv(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h100, 0, SD, 1, 0,       NOP);
        addv(0, 0, 0, 0, 0,             1, 32'h100, 0, SF, 1, 0,       NOP);
        addv(0, 0, 0, 1, ins(32'h100),  0, 32'h100, 0, SW, 1, 0,       NOP);
        addv(0, 0, 0, 0, 0,             1, 32'h104, 1, SF, 1, 32'h100, ins(32'h100));
        addv(1, 32'h200, 0, 1, ins(32'h104), 0, 32'h104, 0, SW, 0, 0,  0);
        addv(0, 0, 1, 0, 0,             1, 32'h200, 0, SF, 1, 0,       NOP);
        addv(0, 0, 0, 1, ins(32'h200),  0, 32'h200, 0, SW, 1, 0,       NOP);
        addv(1, 32'h303, 0, 0, 0,       0, 32'h204, 1, SF, 1, 32'h200, ins(32'h200));
        addv(0, 0, 0, 0, 0,             1, 32'h300, 0, SF, 1, 0,       NOP);
        addv(0, 0, 0, 1, ins(32'h300),  0, 32'h300, 0, SW, 1, 0,       NOP);
        addv(0, 0, 0, 0, 0,             1, 32'h304, 1, SF, 1, 32'h300, ins(32'h300));
        addv(0, 0, 0, 0, 0,             0, 32'h304, 0, SW, 0, 0,       0);
        addv(0, 0, 0, 1, ins(32'h304),  0, 32'h304, 0, SW, 0, 0,       0);
        addv(0, 0, 1, 0, 0,             0, 32'h308, 1, SF, 1, 32'h304, ins(32'h304));
        addv(0, 0, 0, 0, 0,             1, 32'h308, 1, SF, 1, 32'h304, ins(32'h304));

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].br, vecs[i].npc, vecs[i].stl, vecs[i].rv, vecs[i].rd);
            #1;
            expect_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
                        vecs[i].e_st, vecs[i].chk_instr, vecs[i].e_pc, vecs[i].e_instr);
            @(negedge clk);
        end

        // Async reset while a request for 0x308 is outstanding.
        drive(0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_state", {30'd0, dbg_state}, {30'd0, SW});
        #2 rst = 1'b1;
        #1;
        pending = 1'b0;
        expect_outs("async_rst", 0, 32'h0, 0, SF, 1, 0, NOP);
        chk("async_rst_pc", if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'hBAD0_BAD0);
        #1 expect_outs("late_rvalid", 1, 32'h0, 0, SF, 1, 0, NOP);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1 expect_outs("post_rst_wait", 0, 32'h0, 0, SW, 1, 0, NOP);
        @(negedge clk);
        drive(0, 0, 0, 1, ins(32'h0));
        #1 expect_outs("post_rst_resp", 0, 32'h0, 0, SW, 1, 0, NOP);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1 expect_outs("post_rst_cap", 1, 32'h4, 1, SF, 1, 32'h0, ins(32'h0));

        // PC wrap on an instance reset to the last word of the address space.
        @(negedge clk);
        r2_rst = 1'b0;
        #1;
        chk("wrap_req0", {31'd0, r2_req}, 32'd1);
        chk("wrap_addr0", r2_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        r2_rvalid = 1'b1; r2_rdata = ins(32'hFFFF_FFFC);
        #1 chk("wrap_req_wait", {31'd0, r2_req}, 32'd0);
        @(negedge clk);
        r2_rvalid = 1'b0;
        #1;
        chk("wrap_valid", {31'd0, r2_valid}, 32'd1);
        chk("wrap_pc", r2_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", r2_instr, ins(32'hFFFF_FFFC));
        chk("wrap_req1", {31'd0, r2_req}, 32'd1);
        chk("wrap_addr1", r2_addr, 32'h0000_0000);
        @(negedge clk);
        r2_rvalid = 1'b1; r2_rdata = ins(32'h0);
        @(negedge clk);
        r2_rvalid = 1'b0;
        #1;
        chk("wrap_pc2", r2_pc, 32'h0000_0000);
        chk("wrap_instr2", r2_instr, ins(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
